// File: rtl/cdc_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_fifo_pkg
// Description : Shared helpers for the gray-coded dual-clock FIFO.
//               ptr_width(log_depth) gives the pointer width. That width is
//               one bit wider than the address, so full and empty can be told
//               apart.
//               Pointer type convention: each user declares
//                   localparam int PW = ptr_width(LOG_DEPTH);
//                   typedef logic [PW-1:0] ptr_t;
//               The width follows the instance's LOG_DEPTH parameter, so a
//               package-level typedef cannot express it.
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_fifo_pkg;

    localparam int DEFAULT_LOG_DEPTH = 3;

    function automatic int ptr_width(input int log_depth);
        return log_depth + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/binary_to_gray.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_gray
// Description : Combinational binary to reflected-gray converter.
// Ports       : bin  - binary input  (WIDTH)
//               gray - gray output   (WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module binary_to_gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule
`default_nettype wire

// File: rtl/cdc_fifo_wptr_ctrl_sync.sv
`default_nettype none
// ============================================================================
// Module      : cdc_ptr_sync
// Description : N-stage flop synchroniser for a gray-coded pointer.
//               The pointer changes by one bit at a time, so a
//               metastability-resolved capture is always either the old value
//               or the new value.
// Ports       : clk_i  - destination-domain clock
//               rst_ni - asynchronous active-low reset (stages clear to 0)
//               d_i    - gray pointer from the foreign domain (WIDTH)
//               q_o    - synchronised pointer, last stage    (WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/gray_to_binary.sv
`default_nettype none
// ============================================================================
// Module      : gray_to_binary
// Description : Combinational reflected-gray to binary converter.
//               Each binary bit is the XOR of all gray bits at or above it.
// Ports       : gray - gray input    (WIDTH)
//               bin  - binary output (WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module gray_to_binary #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdc_fifo_wptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cdc_fifo_wptr_ctrl
// Description : Write-side pointer controller of the gray-coded dual-clock
//               FIFO. It accepts pushes over valid/ready, drives the storage
//               write port and keeps the binary and gray write pointers. It
//               derives full and fill level from the gray read pointer that
//               arrives from the sink domain.
// Option      : CDC_FIFO_RPTR_SYNC_EN
//               Defined   - rptr_gray_i passes through a 2-flop synchroniser.
//               Undefined - rptr_gray_i is used directly. The caller must
//                           supply an already-synchronised, flop-driven value.
// Ports       : clk_i       - source-domain clock
//               rst_ni      - asynchronous active-low reset
//               src_valid_i - push request
//               src_ready_o - controller can accept a push
//               wr_en_o     - storage write strobe
//               wr_addr_o   - storage write address    (LOG_DEPTH)
//               wptr_gray_o - gray write pointer, exported to the sink domain
//               rptr_gray_i - gray read pointer from the sink domain
//               fill_o      - occupancy seen from the source side, 0..DEPTH
//               full_o      - FIFO full
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_fifo_wptr_ctrl
    import cdc_fifo_pkg::*;
#(
    parameter int LOG_DEPTH = DEFAULT_LOG_DEPTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    output logic                 wr_en_o,
    output logic [LOG_DEPTH-1:0] wr_addr_o,
    output logic [LOG_DEPTH:0]   wptr_gray_o,
    input  logic [LOG_DEPTH:0]   rptr_gray_i,
    output logic [LOG_DEPTH:0]   fill_o,
    output logic                 full_o
);

    localparam int PW = ptr_width(LOG_DEPTH);
    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t DEPTH_P = ptr_t'(1) << LOG_DEPTH;

    ptr_t wptr_bin_q;
    ptr_t wptr_gray_q;
    ptr_t wptr_bin_nxt;
    ptr_t wptr_gray_nxt;
    ptr_t rptr_eff;
    ptr_t rptr_bin;
    ptr_t fill_raw;
    logic push;

`ifdef CDC_FIFO_RPTR_SYNC_EN
    cdc_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (2)
    ) u_rptr_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (rptr_gray_i),
        .q_o    (rptr_eff)
    );
`else
    assign rptr_eff = rptr_gray_i;
`endif

    gray_to_binary #(
        .WIDTH (PW)
    ) u_rptr_g2b (
        .gray (rptr_eff),
        .bin  (rptr_bin)
    );

    // Modulo-2**PW difference. The extra pointer bit makes DEPTH distinct
    // from 0.
    assign fill_raw = wptr_bin_q - rptr_bin;

    // Anything at or above DEPTH counts as full. Values above DEPTH are a
    // protocol error and are reported as a saturated DEPTH.
    assign full_o      = (fill_raw >= DEPTH_P);
    assign fill_o      = full_o ? DEPTH_P : fill_raw;
    assign src_ready_o = ~full_o;

    // Gating with rst_ni drops an in-flight push the moment reset asserts,
    // without waiting for a clock edge.
    assign push      = src_valid_i & src_ready_o & rst_ni;
    assign wr_en_o   = push;
    assign wr_addr_o = wptr_bin_q[LOG_DEPTH-1:0];

    assign wptr_bin_nxt = wptr_bin_q + ptr_t'(1);

    binary_to_gray #(
        .WIDTH (PW)
    ) u_wptr_b2g (
        .bin  (wptr_bin_nxt),
        .gray (wptr_gray_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_bin_q  <= '0;
            wptr_gray_q <= '0;
        end else if (push) begin
            wptr_bin_q  <= wptr_bin_nxt;
            wptr_gray_q <= wptr_gray_nxt;
        end
    end

    // Straight from the flop: the sink domain samples this asynchronously.
    assign wptr_gray_o = wptr_gray_q;

`ifndef SYNTHESIS
    // The controller recovers by saturating, so the overflow is reported and
    // the simulation carries on.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (fill_raw <= DEPTH_P)
            else $warning("cdc_fifo_wptr_ctrl: read pointer implies fill %0d above depth %0d",
                          fill_raw, DEPTH_P);
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/cdc_fifo_wptr_ctrl.md
Name: cdc_fifo_wptr_ctrl

Overview:
Write-side pointer controller for the gray-coded dual-clock FIFO. It runs in the source clock domain and performs four jobs:
- accepts pushes over a valid/ready handshake;
- drives the write port of the storage array;
- keeps the binary and gray write pointers;
- derives full and fill level from the read pointer, which arrives from the sink domain in gray code.

The exported gray pointer changes by exactly one bit per push, so the sink side can synchronise it safely.

Parameters:
LOG_DEPTH, 3, log2 of FIFO depth; DEPTH = 2**LOG_DEPTH; pointer width PW = LOG_DEPTH+1; legal range >= 1

Ports:
clk_i  in  1  source-domain clock
rst_ni  in  1  asynchronous active-low reset
src_valid_i  in  1  push request
src_ready_o  out  1  controller can accept a push
wr_en_o  out  1  storage write strobe
wr_addr_o  out  LOG_DEPTH  storage write address
wptr_gray_o  out  PW  gray write pointer, exported to the sink domain
rptr_gray_i  in  PW  gray read pointer from the sink domain
fill_o  out  PW  occupancy as seen from the source side, 0..DEPTH
full_o  out  1  FIFO full

Behaviour:
- State: wptr_bin_q[PW-1:0] and wptr_gray_q[PW-1:0].
- Reset (async, rst_ni=0): both pointers = 0. Outputs are then src_ready_o=1, full_o=0, fill_o=0, wr_en_o=0.
- Read pointer decode: rptr_bin = gray-to-binary(rptr_eff), where rptr_eff is rptr_gray_i, or the synchronised copy when the optional feature is enabled.
- Fill: fill = (wptr_bin_q - rptr_bin) mod 2**PW, PW bits wide, wrapping by design.
- Full: full_o = (fill >= DEPTH).
  - A fill value above DEPTH is a protocol error. The controller treats it as full and saturates: fill_o = DEPTH.
  - Under simulation, an error is flagged by an assertion.
- Ready: src_ready_o = !full_o. It never depends combinationally on src_valid_i.
- Push: push = src_valid_i & src_ready_o.
  - wr_en_o = push, combinational in the push cycle.
  - wr_addr_o = wptr_bin_q[LOG_DEPTH-1:0].
  - Data is written at the same clock edge on which the pointer advances.
- Pointer update on a push: wptr_bin_q <= wptr_bin_q+1, wrapping from 2**PW-1 to 0.
- Gray pointer: wptr_gray_q <= binary-to-gray(wptr_bin_q+1) in the same edge.
- wptr_gray_o is driven directly from the wptr_gray_q flop, with no logic after it, so the export is glitch-free.
- Latency:
  - A push is visible on wptr_gray_o and fill_o in the following cycle.
  - A read-pointer change is visible on full_o/src_ready_o in the same cycle (feature off) or 2 cycles later (feature on).
- Simultaneous push and read-pointer advance: both take effect, so fill is unchanged.
- Full boundary: the push that brings fill to DEPTH is accepted. src_ready_o falls in the next cycle.
- Reset mid-operation: all state clears asynchronously. Any in-flight push is dropped, and wr_en_o falls immediately.

Optional Feature:
Macro CDC_FIFO_RPTR_SYNC_EN.
- Defined: a 2-flop synchroniser (reset value 0, clocked by clk_i) sits on rptr_gray_i, and rptr_eff is the second stage. Full deasserts 2 cycles after the input changes. Full is pessimistic, never optimistic.
- Undefined: rptr_eff = rptr_gray_i directly. The caller must supply an already-synchronised, flop-driven pointer.

Decomposition:
- Package cdc_fifo_pkg holds:
  - the function ptr_width(log_depth) returning log_depth+1;
  - the typedef-generating parameter convention for ptr_t.
- Existing binary_to_gray and gray_to_binary modules are instantiated for the conversions; they are not re-coded.
- One natural sub-module: cdc_ptr_sync. It is a parameterised N-stage gray pointer synchroniser with async active-low reset, instantiated only under CDC_FIFO_RPTR_SYNC_EN.

Test Plan:
All scenarios use LOG_DEPTH=3.
- Reset: rst_ni=0 -> wptr_gray_o=4'b0000, fill_o=0, full_o=0, src_ready_o=1, wr_en_o=0.
- Fill to full: rptr_gray_i=0, src_valid_i=1 for 9 cycles -> 8 pushes with wr_addr_o=0..7. Then full_o=1, src_ready_o=0, fill_o=8, wptr_gray_o=4'b1100. The 9th cycle shows no wr_en_o.
- Release: at full, rptr_gray_i goes 0000->0001 -> fill_o=7 and src_ready_o=1 in the same cycle (feature off) or after 2 cycles (feature on).
- Wrap-around: 20 pushes with the read pointer trailing by 2 -> wptr_gray_o changes exactly one bit per push, goes 4'b1000 (bin 15) -> 4'b0000, and wr_addr_o wraps 7->0.
- Simultaneous events: fill=7, push while rptr advances one step -> fill_o stays 7 and full_o stays 0. Corrupt rptr with fill computing to 12 -> full_o=1, fill_o=8, assertion fires.
- Reset mid-operation: at fill=5 with src_valid_i=1, pulse rst_ni low mid-cycle -> wr_en_o=0 and all pointers 0 immediately, without waiting for a clock edge.
